// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - ALU SELECT codes for the M-extension ops (ALU_MUL..ALU_REMU)
//   - 3-bit op codes latched from SELECT[2:0]
//   - FSM state encoding (2-bit: IDLE, MUL, DIV, FIN)
//   - default operand width
// The ALU and hazard unit import the same package so the codes stay in one place.
package muldiv_sequencer_pkg;

   localparam int WIDTH_DEF = 32;

   // Full 5-bit SELECT codes; M-extension ops all live in the 5'b01xxx group.
   localparam logic [1:0] MD_GROUP   = 2'b01;
   localparam logic [4:0] ALU_MUL    = 5'b01000;
   localparam logic [4:0] ALU_MULH   = 5'b01001;
   localparam logic [4:0] ALU_MULHSU = 5'b01010;
   localparam logic [4:0] ALU_MULHU  = 5'b01011;
   localparam logic [4:0] ALU_DIV    = 5'b01100;
   localparam logic [4:0] ALU_DIVU   = 5'b01101;
   localparam logic [4:0] ALU_REM    = 5'b01110;
   localparam logic [4:0] ALU_REMU   = 5'b01111;

   // Op code as latched at accept (SELECT[2:0]).
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // DIV and REM are the signed divide ops (bit 2 set, bit 0 clear).
   function automatic logic op_div_signed(input logic [2:0] op);
      return op[2] & ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational radix-2 restoring division step.
//   rem, quo      : current partial remainder and quotient/dividend shift register
//   divisor       : divisor magnitude
//   rem_next      : partial remainder after this step
//   quo_next      : quotient register after this step (new quotient bit in LSB)
// The dividend is shifted out of the top of quo into rem one bit per step while
// quotient bits enter at the bottom, so after WIDTH steps quo holds the quotient.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      if (shifted >= {1'b0, divisor}) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle EX-stage controller for the RV32M ops (SELECT 5'b01xxx).
// Accepts one op in IDLE, runs it, then presents result with a one-cycle done pulse.
// Multiplies register a 2*WIDTH-bit product in one cycle; divides/remainders run a
// WIDTH-step restoring divider on operand magnitudes with sign fix-up in FIN.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      op request, sampled only in IDLE
//   select     ALU op code; only 5'b01xxx is accepted
//   data1      rs1 operand (dividend / multiplicand)
//   data2      rs2 operand (divisor / multiplier)
//   abort      pipeline flush; returns to IDLE at the next edge from any state
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse, result valid in that cycle
//   result     op result; holds until the next completed op
//   dbg_state  current FSM state for observation
// Handshake: an op is accepted at a clk edge where state is IDLE, start=1,
// select[4:3]=2'b01 and abort=0. start is ignored while busy; the requester
// holds the op until busy falls. done is never asserted in a cycle with abort.
// Configuration macro: MULDIV_EARLY_OUT_EN -- when defined, divide-by-zero and
// signed overflow skip the divider and complete in cycle 1.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [4:0]       select,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output state_t           dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   logic [2:0]         op;
   logic [WIDTH-1:0]   opa;        // multiplicand
   logic [WIDTH-1:0]   opb;        // multiplier, or divisor magnitude
   logic [WIDTH-1:0]   d1;         // original dividend, for REM by zero
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [CW-1:0]      cnt;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   result_q;

   // Accept-time decode
   logic               accept;
   logic               sgn_in;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               zero_in;
   logic               ovf_in;

   always_comb begin
      accept  = (state == ST_IDLE) && start && (select[4:3] == MD_GROUP) && !abort;
      sgn_in  = op_div_signed(select[2:0]);
      a_neg   = sgn_in & data1[WIDTH-1];
      b_neg   = sgn_in & data2[WIDTH-1];
      abs_a   = a_neg ? -data1 : data1;
      abs_b   = b_neg ? -data2 : data2;
      zero_in = (data2 == '0);
      ovf_in  = sgn_in && (data1 == MIN_NEG) && (data2 == '1);
   end

   // Multiplier: extend both operands to 2*WIDTH by op signedness; the low
   // 2*WIDTH bits of the modular product equal the exact signed/unsigned product.
   logic               mul_a_sgn;
   logic               mul_b_sgn;
   logic [2*WIDTH-1:0] mul_a;
   logic [2*WIDTH-1:0] mul_b;
   logic [2*WIDTH-1:0] mul_full;

   always_comb begin
      mul_a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
      mul_b_sgn = (op == OP_MULH);
      mul_a     = {{WIDTH{mul_a_sgn & opa[WIDTH-1]}}, opa};
      mul_b     = {{WIDTH{mul_b_sgn & opb[WIDTH-1]}}, opb};
      mul_full  = mul_a * mul_b;
   end

   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   muldiv_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (opb),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   // Final value in FIN: word select for multiplies, sign fix-up and the
   // divide-by-zero / overflow overrides for divides.
   logic [WIDTH-1:0] fin_val;

   always_comb begin
      fin_val = '0;
      case (op)
         OP_MUL:                        fin_val = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fin_val = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU: begin
            if (div_zero)      fin_val = '1;
            else if (div_ovf)  fin_val = MIN_NEG;
            else               fin_val = neg_q ? -quo : quo;
         end
         default: begin
            if (div_zero)      fin_val = d1;
            else if (div_ovf)  fin_val = '0;
            else               fin_val = neg_r ? -rem : rem;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         op       <= '0;
         opa      <= '0;
         opb      <= '0;
         d1       <= '0;
         prod     <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         result_q <= '0;
      end else if (abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op       <= select[2:0];
                  opa      <= data1;
                  d1       <= data1;
                  rem      <= '0;
                  cnt      <= '0;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= zero_in;
                  div_ovf  <= ovf_in;
                  if (select[2]) begin
                     opb <= abs_b;
                     quo <= abs_a;
`ifdef MULDIV_EARLY_OUT_EN
                     state <= (zero_in || ovf_in) ? ST_FIN : ST_DIV;
`else
                     state <= ST_DIV;
`endif
                  end else begin
                     opb   <= data2;
                     state <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               prod  <= mul_full;
               state <= ST_FIN;
            end
            ST_DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) state <= ST_FIN;
            end
            ST_FIN: begin
               result_q <= fin_val;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // In FIN the fresh value is shown directly; abort in that cycle cancels both
   // the pulse and the update, leaving result at its previous value.
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN) && !abort;
   assign result    = done ? fin_val : result_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer (WIDTH=32). Expected results come
// from a behavioural reference model and are queued when an op is driven.
// Build with or without MULDIV_EARLY_OUT_EN; expected latencies follow the macro.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [4:0]  select;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        abort;
   logic        busy;
   logic        done;
   logic [31:0] result;
   state_t      dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .select    (select),
      .data1     (data1),
      .data2     (data2),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sr;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (sel[2:0])
         3'd0: return a * b;
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            sr = sa / sb; return sr;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            sr = sa % sb; return sr;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] sel, input logic [31:0] a,
                                  input logic [31:0] b);
      if (!sel[2]) return 2;
`ifdef MULDIV_EARLY_OUT_EN
      if (b == 0) return 1;
      if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   // ---------------- check helper ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drives one op, waits (bounded) for done, checks latency and result.
   task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit hold);
      int   c;
      int   lat;
      logic seen;
      logic [31:0] exp;
      exp_q.push_back(model(sel, a, b));
      @(negedge clk);
      start = 1'b1; select = sel; data1 = a; data2 = b;
      @(posedge clk);
      c = 0; lat = 0; seen = 1'b0;
      while (!seen && c < 40) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            check({tag, "/busy1"}, 32'(busy), 32'd1);
            if (!hold) start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      start = 1'b0;
      check({tag, "/done_seen"}, 32'(seen), 32'd1);
      check({tag, "/latency"}, 32'(lat), 32'(exp_lat(sel, a, b)));
      exp = exp_q.pop_front();
      check({tag, "/result"}, result, exp);
      if (seen) last_res = exp;
      @(negedge clk);
      check({tag, "/idle_after"}, {30'd0, busy, done}, 32'd0);
      check({tag, "/result_hold"}, result, last_res);
   endtask

   task automatic count_dones(input int ncyc, output int ndone);
      ndone = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          nd;
      logic [4:0]  rsel;
      logic [31:0] ra;
      logic [31:0] rb;

      reset_n = 1'b0; start = 1'b0; select = '0; data1 = '0; data2 = '0; abort = 1'b0;
      repeat (2) @(negedge clk);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/result", result, 32'd0);
      check("reset/state", 32'(dbg_state), 32'(ST_IDLE));
      reset_n = 1'b1;
      @(negedge clk);

      // multiplies
      run_op(ALU_MUL,    32'd5,         32'd2,         "mul_5x2", 0);
      run_op(ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1", 0);
      run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1", 0);
      run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", 0);

      // divides
      run_op(ALU_DIV,  32'd7,          32'd2, "div_7_2", 0);
      run_op(ALU_REM,  32'hFFFF_FFF9,  32'd2, "rem_m7_2", 0);
      run_op(ALU_DIVU, 32'hFFFF_FFFE,  32'd2, "divu_big", 0);
      run_op(ALU_REMU, 32'd5,          32'd2, "remu_5_2", 0);

      // divide by zero and signed overflow
      run_op(ALU_DIV,  32'd5,         32'd0,         "div_by0", 0);
      run_op(ALU_REMU, 32'd5,         32'd0,         "remu_by0", 0);
      run_op(ALU_REM,  32'hFFFF_FFF9, 32'd0,         "rem_neg_by0", 0);
      run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
      run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);

      // abort in cycle 10 of a divide
      @(negedge clk);
      start = 1'b1; select = ALU_DIV; data1 = 32'd100; data2 = 32'd7;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 2) check("abort/state_div", 32'(dbg_state), 32'(ST_DIV));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/done", 32'(done), 32'd0);
      check("abort/result", result, last_res);
      count_dones(36, nd);
      check("abort/no_done", 32'(nd), 32'd0);
      run_op(ALU_MUL, 32'd3, 32'd4, "mul_after_abort", 0);

      // abort together with start in IDLE is not an accept
      @(negedge clk);
      start = 1'b1; select = ALU_MUL; data1 = 32'd9; data2 = 32'd9; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start/busy", 32'(busy), 32'd0);

      // asynchronous reset in cycle 5 of a divide
      @(negedge clk);
      start = 1'b1; select = ALU_DIVU; data1 = 32'd1000; data2 = 32'd3;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      check("areset/busy", 32'(busy), 32'd0);
      check("areset/done", 32'(done), 32'd0);
      check("areset/result", result, 32'd0);
      last_res = '0;
      @(negedge clk);
      reset_n = 1'b1;
      count_dones(36, nd);
      check("areset/no_done", 32'(nd), 32'd0);

      // non-M op is ignored
      @(negedge clk);
      start = 1'b1; select = 5'b00000; data1 = 32'd1; data2 = 32'd2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("add_ignored/busy", {30'd0, busy, done}, 32'd0);
      end
      start = 1'b0;

      // start held during busy: exactly one done
      run_op(ALU_DIVU, 32'd9, 32'd2, "divu_hold", 1);
      count_dones(36, nd);
      check("hold/extra_done", 32'(nd), 32'd0);

      // random ops
      for (int i = 0; i < 8; i++) begin
         rsel = {MD_GROUP, 3'($urandom_range(0, 7))};
         ra   = $urandom;
         rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
         if ($urandom_range(0, 1) == 1) ra[31] = 1'b1;
         run_op(rsel, ra, rb, "random", 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
